pattern_scan_arbiter: RTL and testbench

Shares one serial "101" pattern detector (Moore FSM, one input bit per clock, overlapping matches, registered output) among NUM_REQ requesters. Each requester submits a WIDTH-bit word. The block arbitrates round-robin, clears the detector, and shifts the granted word into it MSB first. It counts detector matches and returns the count and requester ID through a valid/ready response. It sits between the requester blocks and the detector instance, and is the only driver of the detector's input and clear.

---
 rtl/pattern_scan_arbiter.sv | 166 ++++++++++++++++
 tb/tb_pattern_scan_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_arbiter.sv
// pattern_scan_arbiter
// Round-robin front end that shares one serial "101" detector among
// NUM_REQ requesters. A granted word is shifted into the detector MSB first,
// detector matches are counted, and the count goes back with the requester
// ID over a valid/ready response.
module pattern_scan_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = $clog2(NUM_REQ),
  parameter int CNTW    = $clog2(WIDTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     det_in,
  output logic                     det_clear,
  input  logic                     det_out,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [CNTW-1:0]          resp_count
);

  // Bit-index width. WIDTH is at least 2, so this is never zero.
  localparam int IXW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [IDW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [IDW-1:0]    id_reg, id_next;
  logic [WIDTH-1:0]  word_reg, word_next;
  logic [IXW-1:0]    idx_reg, idx_next;
  logic [CNTW-1:0]   count_reg, count_next;

  // Arbitration results
  logic              found;
  logic [IDW-1:0]    winner;
  logic [IDW:0]      cand_sum;

  // Unpacked view of the request words
  logic [WIDTH-1:0]  req_word [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin search: first valid requester after rr_ptr, wrapping.
  // rr_ptr + k never exceeds 2*NUM_REQ-1, so one conditional subtract
  // is enough for the modulo.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand_sum = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (IDW+1)'(NUM_REQ);
      end
      if (!found && req_valid[cand_sum[IDW-1:0]]) begin
        found  = 1'b1;
        winner = cand_sum[IDW-1:0];
      end
    end
  end

  // State and datapath registers; reset aborts any in-flight word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= IDW'(NUM_REQ - 1);
      id_reg     <= '0;
      word_reg   <= '0;
      idx_reg    <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      id_reg     <= id_next;
      word_reg   <= word_next;
      idx_reg    <= idx_next;
      count_reg  <= count_next;
    end
  end

  // Next-state, datapath updates and all outputs.
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    id_next     = id_reg;
    word_next   = word_reg;
    idx_next    = idx_reg;
    count_next  = count_reg;
    req_ready   = '0;
    det_in      = 1'b0;
    det_clear   = 1'b0;
    resp_valid  = 1'b0;
    resp_id     = '0;
    resp_count  = '0;

    case (state_reg)
      IDLE: begin
        if (found) begin
          // Grant is only offered while the winner is valid, so a grant
          // here is always an accept.
          req_ready   = NUM_REQ'(1) << winner;
          word_next   = req_word[winner];
          id_next     = winner;
          rr_ptr_next = winner;
          count_next  = '0;
          state_next  = CLEAR;
        end
      end

      CLEAR: begin
        det_clear  = 1'b1;
        idx_next   = IXW'(WIDTH - 1);
        state_next = SHIFT;
      end

      SHIFT: begin
        det_in = word_reg[idx_reg];
        // det_out lags its input by one cycle; on the first shift cycle
        // it still shows the cleared state, so it is not counted.
        if (idx_reg != IXW'(WIDTH - 1)) begin
          count_next = count_reg + CNTW'(det_out);
        end
        if (idx_reg == '0) begin
          state_next = DRAIN;
        end else begin
          idx_next = idx_reg - 1'b1;
        end
      end

      DRAIN: begin
        // Pick up the detector result for the final bit.
        count_next = count_reg + CNTW'(det_out);
        state_next = DONE;
      end

      DONE: begin
        resp_valid = 1'b1;
        resp_id    = id_reg;
        resp_count = count_reg;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Self-checking bench for pattern_scan_arbiter with a behavioural "101"
// Moore detector attached to the det_* ports.
module tb_pattern_scan_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           det_in;
  logic           det_clear;
  logic           det_out;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_id;
  logic [3:0]     resp_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  pattern_scan_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .det_in     (det_in),
    .det_clear  (det_clear),
    .det_out    (det_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_count (resp_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Detector: 0 idle, 1 saw "1", 2 saw "10", 3 saw "101" (out=1).
  // Deliberately not tied to reset: only det_clear initialises it.
  logic [1:0] dst = 2'd0;
  always @(posedge clock) begin
    if (det_clear) dst <= 2'd0;
    else begin
      case (dst)
        2'd0:    dst <= det_in ? 2'd1 : 2'd0;
        2'd1:    dst <= det_in ? 2'd1 : 2'd2;
        2'd2:    dst <= det_in ? 2'd3 : 2'd0;
        default: dst <= det_in ? 2'd1 : 2'd2;
      endcase
    end
  end
  assign det_out = (dst == 2'd3);

  typedef struct {
    int         r;
    logic [7:0] d;
    int         exp_id;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  // One full job with resp_ready high; checks grant, clear, bit stream,
  // latency and the response.
  task automatic run_job(input int r, input logic [7:0] d, input int exp_id, input int exp_cnt);
    logic [3:0] oh;
    int         t_acc;
    bit         got;
    oh = 4'b0001 << r;
    req_data[r*W +: W] = d;
    req_valid  = oh;
    resp_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      #1;
      if (req_ready != '0) got = 1'b1;
      else tick();
    end
    if (!got) begin
      check("grant_timeout", 32'd0, 32'd1);
      req_valid = '0;
      return;
    end
    check("req_ready_onehot", req_ready, oh);
    t_acc = cyc;
    tick();
    req_valid = '0;
    #1;
    check("clear_pulse", det_clear, 1);
    check("clear_det_in", det_in, 0);
    check("req_ready_busy", req_ready, 0);
    for (int i = 0; i < W; i++) begin
      tick();
      #1;
      check("det_in_bit", det_in, d[W-1-i]);
      check("no_clear_in_shift", det_clear, 0);
    end
    tick();
    #1;
    check("drain_det_in", det_in, 0);
    tick();
    #1;
    check("resp_valid", resp_valid, 1);
    check("resp_latency", cyc - t_acc, W + 3);
    check("resp_id", resp_id, exp_id);
    check("resp_count", resp_count, exp_cnt);
    $display("job req=%0d data=%b id=%0d count=%0d", r, d, resp_id, resp_count);
    tick();
    #1;
    check("resp_valid_drop", resp_valid, 0);
  endtask

  int         gid[5];
  int         gcyc[5];
  int         n;
  int         exp_order[5];
  int         seen;
  bit         got;

  initial begin
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b0;

    vecs[0] = '{0, 8'b10101101, 0, 3};
    vecs[1] = '{2, 8'h00,       2, 0};
    vecs[2] = '{2, 8'hFF,       2, 0};
    vecs[3] = '{1, 8'b11011011, 1, 2};
    vecs[4] = '{3, 8'b10100101, 3, 2};
    exp_order = '{0, 1, 2, 3, 0};

    // Reset state
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_det_in", det_in, 0);
    check("rst_det_clear", det_clear, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_count", resp_count, 0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Table of single jobs
    for (int v = 0; v < 5; v++) begin
      run_job(vecs[v].r, vecs[v].d, vecs[v].exp_id, vecs[v].exp_cnt);
    end

    // Round robin with all four requesters held valid
    do_reset();
    req_data   = {8'h11, 8'h22, 8'h33, 8'h44};
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 120 && n < 5; c++) begin
      #1;
      if (req_ready != '0) begin
        for (int b = 0; b < N; b++) if (req_ready[b]) gid[n] = b;
        gcyc[n] = cyc;
        $display("rr grant %0d -> requester %0d at cycle %0d", n, gid[n], gcyc[n]);
        n++;
      end
      tick();
    end
    req_valid = '0;
    check("rr_grant_count", n, 5);
    for (int i = 0; i < n; i++) begin
      check("rr_order", gid[i], exp_order[i]);
      if (i > 0) check("rr_spacing", gcyc[i] - gcyc[i-1], W + 4);
    end

    // Stall in DONE with everyone requesting
    do_reset();
    req_data[0 +: W] = 8'b10101101;
    req_valid  = 4'hF;
    resp_ready = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (resp_valid) got = 1'b1;
      else tick();
    end
    check("stall_resp_seen", got, 1);
    for (int c = 0; c < 20; c++) begin
      check("stall_valid", resp_valid, 1);
      check("stall_id", resp_id, 0);
      check("stall_count", resp_count, 3);
      check("stall_req_ready", req_ready, 0);
      tick();
      #1;
    end
    $display("stall held id=%0d count=%0d", resp_id, resp_count);
    resp_ready = 1'b1;
    #1;
    check("stall_release_same_cycle", req_ready, 0);
    tick();
    #1;
    check("stall_release_next_grant", req_ready, 4'b0010);
    req_valid = '0;

    // Asynchronous reset in the middle of SHIFT
    do_reset();
    run_job(0, 8'b10101101, 0, 3);
    req_data[0 +: W] = 8'b10101101;
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    #1;
    check("abort_grant", req_ready, 4'b0001);
    tick();            // CLEAR
    req_valid = '0;
    tick();            // SHIFT bit 7
    tick();            // SHIFT bit 6
    tick();            // SHIFT bit 5
    #1;
    check("abort_pre_det_in", det_in, 1);
    reset = 1'b1;
    #1;
    check("abort_det_in", det_in, 0);
    check("abort_det_clear", det_clear, 0);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_req_ready", req_ready, 0);
    check("abort_resp_id", resp_id, 0);
    check("abort_resp_count", resp_count, 0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      #1;
      if (resp_valid) seen++;
    end
    check("abort_no_resp", seen, 0);
    run_job(1, 8'b01010101, 1, 3);

    // Single requester wraps around to itself
    do_reset();
    run_job(3, 8'b10100101, 3, 2);
    run_job(3, 8'b10110101, 3, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
